sata_dma_frame_former: RTL and testbench
========================================

SATA_DMA_FRAME_FORMER -- requirements
Module: sata_dma_frame_former

Interface
REQ-001 Parameter DWIDTH, default 32: stream data width in bits.
REQ-002 Parameter LWIDTH, default 16: transfer length width, counted in beats.
REQ-003 Parameter FRAMELEN, default 2048: maximum beats per output frame; power of two, at least 2.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-006 cmd_len  input  LWIDTH  number of beats in the transfer.
REQ-007 cmd_val  input  1  command request.
REQ-008 cmd_rdy  output  1  command accepted when cmd_val and cmd_rdy are both high.
REQ-009 i_dat  input  DWIDTH  input stream data.
REQ-010 i_val  input  1  input stream valid.
REQ-011 i_rdy  output  1  input stream ready.
REQ-012 o_dat  output  DWIDTH  framed output data.
REQ-013 o_val  output  1  output valid.
REQ-014 o_sop  output  1  first beat of a frame; meaningful only while o_val is high.
REQ-015 o_eop  output  1  last beat of a frame; meaningful only while o_val is high.
REQ-016 o_rdy  input  1  output ready.
REQ-017 busy  output  1  a transfer is in progress.
REQ-018 done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-019 The FSM SHALL have three states: IDLE, XFER and FLUSH.
REQ-020 cmd_rdy SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-021 On a command handshake with cmd_len != 0, the block SHALL load a remaining-beats counter with cmd_len, clear the frame-beat counter, and go to XFER.
REQ-022 On a command handshake with cmd_len == 0, the block SHALL stay in IDLE, produce no beats, and pulse done on the next cycle.
REQ-023 In XFER, i_rdy SHALL equal (~o_val | o_rdy); in IDLE and FLUSH, i_rdy SHALL be 0.
REQ-024 An input beat is accepted when i_val and i_rdy are both high.
REQ-025 An accepted beat SHALL be registered onto o_dat/o_val in the same edge, giving one cycle of latency with no bubble under continuous flow.
REQ-026 o_val SHALL clear on an output handshake if no new beat is accepted in that cycle.
REQ-027 o_sop SHALL be set for a beat accepted while the frame-beat counter is 0.
REQ-028 o_eop SHALL be set for a beat accepted while the frame-beat counter is FRAMELEN-1 or the remaining count is 1.
REQ-029 On each accepted beat, the remaining count SHALL decrement.
REQ-030 On each accepted beat, the frame-beat counter SHALL increment, wrapping to 0 after an eop beat.
REQ-031 A beat accepted while the remaining count is 1 SHALL move the FSM to FLUSH.
REQ-032 In FLUSH, the block SHALL hold o_val/o_dat/o_sop/o_eop stable until o_rdy is high.
REQ-033 On the o_val&o_rdy handshake in FLUSH, the block SHALL pulse done for exactly that cycle and return to IDLE.
REQ-034 While o_val is high and o_rdy is low, o_dat, o_sop and o_eop SHALL NOT change.
REQ-035 For a length of 1, a single beat SHALL carry both o_sop and o_eop.
REQ-036 For a length that is an exact multiple of FRAMELEN, the final beat SHALL carry exactly one eop, and no empty frame SHALL follow.
REQ-037 A new command SHALL NOT be accepted before done has been pulsed.

Reset
REQ-038 On reset assertion, the block SHALL asynchronously force state=IDLE, cmd_rdy=1, i_rdy=0, o_val=0, o_sop=0, o_eop=0, busy=0, done=0, o_dat=0, and clear both counters.
REQ-039 Reset asserted mid-transfer SHALL discard the in-flight beat and remaining count, with no done pulse.
REQ-040 After reset deasserts, the block SHALL be ready to accept a command on the first clock edge.

Verification
REQ-041 FRAMELEN=4, cmd_len=10, i_val and o_rdy held high -> 10 beats out; sop on beats 1, 5 and 9; eop on beats 4, 8 and 10; done one cycle after beat 10 handshakes; no bubbles.
REQ-042 cmd_len=1 -> one beat with sop=1 and eop=1; busy high for 2 cycles with o_rdy=1; single done pulse.
REQ-043 cmd_len=0 -> no o_val; done pulses the cycle after the command handshake; cmd_rdy stays high.
REQ-044 FRAMELEN=4, cmd_len=8, o_rdy toggled randomly and i_val gapped -> output data order matches input order; eop only on beats 4 and 8; o_dat/o_sop/o_eop stable while stalled.
REQ-045 Reset asserted after 3 of 6 beats -> all outputs return to their reset values asynchronously; no done pulse; a following cmd_len=2 produces a sop+eop frame of 2 beats.
REQ-046 cmd_val asserted while busy -> cmd_rdy=0 and the command is ignored until done has been pulsed.

Source files
------------

// File: rtl/sata_dma_frame_former.sv
// sata_dma_frame_former: cuts a DMA transfer of cmd_len beats into sop/eop framed
// bursts of at most FRAMELEN beats, through a one-deep registered output stage.
module sata_dma_frame_former #(
    parameter int DWIDTH   = 32,
    parameter int LWIDTH   = 16,
    parameter int FRAMELEN = 2048
) (
    input  logic              reset,
    input  logic              clk,
    input  logic [LWIDTH-1:0] cmd_len,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [DWIDTH-1:0] i_dat,
    input  logic              i_val,
    output logic              i_rdy,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_val,
    output logic              o_sop,
    output logic              o_eop,
    input  logic              o_rdy,
    output logic              busy,
    output logic              done
);
    localparam int FW = $clog2(FRAMELEN);
    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;
    state_t            state_q, state_d;
    logic [LWIDTH-1:0] rem_q, rem_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [DWIDTH-1:0] o_dat_q, o_dat_d;
    logic              o_val_q, o_val_d, o_sop_q, o_sop_d, o_eop_q, o_eop_d, done_q, done_d;
    logic              acc, last, eop;
    assign cmd_rdy = state_q == IDLE;
    assign busy    = state_q != IDLE;
    assign i_rdy   = state_q == XFER && (!o_val_q || o_rdy);
    assign acc     = i_val && i_rdy;
    assign last    = rem_q == LWIDTH'(1);
    assign eop     = fcnt_q == FW'(FRAMELEN - 1) || last;
    assign o_dat   = o_dat_q;
    assign o_val   = o_val_q;
    assign o_sop   = o_sop_q;
    assign o_eop   = o_eop_q;
    assign done    = done_q;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        fcnt_d  = fcnt_q;
        o_dat_d = o_dat_q;
        o_val_d = o_val_q;
        o_sop_d = o_sop_q;
        o_eop_d = o_eop_q;
        done_d  = 1'b0;
        if (state_q == IDLE && cmd_val) begin
            state_d = cmd_len != '0 ? XFER : IDLE;
            rem_d   = cmd_len;
            fcnt_d  = '0;
            done_d  = cmd_len == '0;
        end
        // a new beat overrides the handshake-driven clear of the output stage
        if (acc) begin
            o_dat_d = i_dat;
            o_val_d = 1'b1;
            o_sop_d = fcnt_q == '0;
            o_eop_d = eop;
            rem_d   = rem_q - 1'b1;
            fcnt_d  = eop ? '0 : fcnt_q + 1'b1;
            state_d = last ? FLUSH : XFER;
        end else if (o_val_q && o_rdy) begin
            o_val_d = 1'b0;
            state_d = state_q == FLUSH ? IDLE : state_q;
            done_d  = state_q == FLUSH;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fcnt_q  <= '0;
            o_dat_q <= '0;
            o_val_q <= 1'b0;
            o_sop_q <= 1'b0;
            o_eop_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fcnt_q  <= fcnt_d;
            o_dat_q <= o_dat_d;
            o_val_q <= o_val_d;
            o_sop_q <= o_sop_d;
            o_eop_q <= o_eop_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_sata_dma_frame_former.sv
// tb_sata_dma_frame_former: table-driven and random transfers checked against a
// frame model derived from beat indices (sop at i%F==0, eop at i%F==F-1 or last).
module tb_sata_dma_frame_former;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int F  = 4;
    logic          clk = 0, reset = 1;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_val = 0, i_val = 0, o_rdy = 0;
    logic [DW-1:0] i_dat = '0;
    logic          cmd_rdy, i_rdy, o_val, o_sop, o_eop, busy, done;
    logic [DW-1:0] o_dat;
    int            vecs = 0, miss = 0;

    typedef struct {
        int len;
        int ival_pct;
        int ordy_pct;
        int nag;
        int exp_frames;
        int exp_busy;
    } vec_t;
    vec_t tv[8];

    sata_dma_frame_former #(.DWIDTH(DW), .LWIDTH(LW), .FRAMELEN(F)) dut (
        .reset(reset), .clk(clk), .cmd_len(cmd_len), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .i_dat(i_dat), .i_val(i_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_val(o_val),
        .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_rdy"}, cmd_rdy, 1);
        check({tag, " i_rdy"}, i_rdy, 0);
        check({tag, " o_val"}, o_val, 0);
        check({tag, " o_sop"}, o_sop, 0);
        check({tag, " o_eop"}, o_eop, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " o_dat"}, o_dat, 0);
    endtask

    // One full transfer; nag keeps a competing command asserted while busy.
    task automatic run(input int len, input int ival_pct, input int ordy_pct, input int nag,
                       input int exp_frames, input int exp_busy);
        logic [DW-1:0] inq[$];
        logic [DW-1:0] hd;
        logic          hs, he;
        int            beats = 0, acc = 0, sops = 0, eops = 0, busy_cnt = 0, cyc = 0;
        bit            exp_done, bexp, seen_done = 0, hold = 0;
        @(posedge clk); #1;
        cmd_len = LW'(len);
        cmd_val = 1;
        i_val   = 0;
        o_rdy   = 0;
        @(negedge clk);
        check("cmd_rdy at issue", cmd_rdy, 1);
        @(posedge clk); #1;
        cmd_val  = 0;
        exp_done = len == 0;
        while (!seen_done && cyc < 2000) begin
            cyc++;
            i_val   = $urandom_range(99) < ival_pct;
            i_dat   = $urandom;
            o_rdy   = $urandom_range(99) < ordy_pct;
            cmd_val = nag != 0 && !exp_done;
            cmd_len = LW'(5);
            @(negedge clk);
            bexp = len != 0 && !exp_done;
            check("done", done, exp_done);
            check("busy", busy, bexp);
            check("cmd_rdy", cmd_rdy, !bexp);
            check("i_rdy", i_rdy, bexp && acc < len && (!o_val || o_rdy));
            if (hold) begin
                check("stall o_val", o_val, 1);
                check("stall o_dat", o_dat, hd);
                check("stall o_sop", o_sop, hs);
                check("stall o_eop", o_eop, he);
            end
            seen_done = done;
            busy_cnt += int'(busy);
            if (i_val && i_rdy) begin
                inq.push_back(i_dat);
                acc++;
            end
            exp_done = 0;
            if (o_val && o_rdy) begin
                if (beats >= inq.size() || beats >= len) begin
                    vecs++;
                    miss++;
                    $display("FAIL extra beat: beat %0d with %0d accepted, len %0d", beats, inq.size(), len);
                end else begin
                    check("o_dat order", o_dat, inq[beats]);
                    check("o_sop", o_sop, beats % F == 0);
                    check("o_eop", o_eop, beats % F == F - 1 || beats == len - 1);
                end
                sops += int'(o_sop);
                eops += int'(o_eop);
                beats++;
                exp_done = beats == len;
            end
            hold = o_val && !o_rdy;
            hd   = o_dat;
            hs   = o_sop;
            he   = o_eop;
            @(posedge clk); #1;
        end
        if (!seen_done) begin
            vecs++;
            miss++;
            $display("FAIL timeout: no done for len %0d after %0d cycles", len, cyc);
        end
        check("beat count", beats, len);
        check("sop count", sops, exp_frames);
        check("eop count", eops, exp_frames);
        if (exp_busy >= 0) check("busy cycles", busy_cnt, exp_busy);
        i_val   = 0;
        o_rdy   = 0;
        cmd_val = 0;
    endtask

    initial begin
        tv[0] = '{10, 100, 100, 0, 3, 11};
        tv[1] = '{1, 100, 100, 0, 1, 2};
        tv[2] = '{0, 100, 100, 0, 0, 0};
        tv[3] = '{8, 60, 50, 0, 2, -1};
        tv[4] = '{4, 100, 100, 0, 1, 5};
        tv[5] = '{5, 100, 100, 1, 2, 6};
        tv[6] = '{12, 70, 70, 1, 3, -1};
        tv[7] = '{3, 100, 30, 0, 1, -1};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 8; i++)
            run(tv[i].len, tv[i].ival_pct, tv[i].ordy_pct, tv[i].nag, tv[i].exp_frames, tv[i].exp_busy);

        // reset after 3 of 6 beats
        @(posedge clk); #1;
        cmd_len = LW'(6);
        cmd_val = 1;
        i_val   = 1;
        o_rdy   = 1;
        i_dat   = 32'hA5A5_0001;
        @(posedge clk); #1;
        cmd_val = 0;
        repeat (3) begin
            @(posedge clk); #1;
            i_dat = i_dat + 1;
        end
        check("mid o_val", o_val, 1);
        check("mid busy", busy, 1);
        #2 reset = 1;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        check("reset done", done, 0);
        i_val = 0;
        o_rdy = 0;
        reset = 0;
        run(2, 100, 100, 0, 1, 3);

        for (int i = 0; i < 25; i++) begin
            int len;
            len = $urandom_range(20, 1);
            run(len, $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(1, 0), (len + F - 1) / F, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
